// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Holds the architectural sizes, the writeback request record and a one-hot decoder.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    // One-hot decode of a register address into a per-register bit vector.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
        logic [NUM_REGS-1:0] one_s;
        one_s = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one_s << addr;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; last_grant records the most recent winner.
// Reset value 1 makes requester 0 win the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant selection and winner tracking.
    always_comb begin
        grant_o      = 2'b00;
        last_grant_d = last_grant_q;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        if (grant_o[1]) begin
            last_grant_d = 1'b1;
        end else if (grant_o[0]) begin
            last_grant_d = 1'b0;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Winner register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and LSU writeback sources
// and tracks per-register outstanding writes for hazard detection.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [ADDR_W-1:0]   alloc_addr,
    input  logic                flush,
    input  logic                src0_valid,
    output logic                src0_ready,
    input  logic [ADDR_W-1:0]   src0_addr,
    input  logic [DATA_W-1:0]   src0_data,
    input  logic                src1_valid,
    output logic                src1_ready,
    input  logic [ADDR_W-1:0]   src1_addr,
    input  logic [DATA_W-1:0]   src1_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] pending,
    output logic                alloc_err
);

    wb_req_t             req0_s;
    wb_req_t             req1_s;
    wb_req_t             sel_s;
    logic [1:0]          grant_s;
    logic [NUM_REGS-1:0] set_vec_s;
    logic [NUM_REGS-1:0] clr_vec_s;
    logic                alloc_hit_s;

    logic                wr_en_q,     wr_en_d;
    reg_addr_t           wr_addr_q,   wr_addr_d;
    reg_data_t           wr_data_q,   wr_data_d;
    logic [NUM_REGS-1:0] pending_q,   pending_d;
    logic                alloc_err_q, alloc_err_d;

    assign req0_s = '{valid: src0_valid, addr: src0_addr, data: src0_data};
    assign req1_s = '{valid: src1_valid, addr: src1_addr, data: src1_data};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({req1_s.valid, req0_s.valid}),
        .grant_o (grant_s)
    );

    assign src0_ready = grant_s[0];
    assign src1_ready = grant_s[1];

    // Output stage: the granted request is written one cycle later; r0 is swallowed.
    always_comb begin
        sel_s     = req0_s;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_s[1]) begin
            sel_s = req1_s;
        end else begin
            sel_s = req0_s;
        end
        if (grant_s != 2'b00) begin
            wr_en_d   = (sel_s.addr != REG_ZERO);
            wr_addr_d = sel_s.addr;
            wr_data_d = sel_s.data;
        end else begin
            wr_en_d   = 1'b0;
        end
    end

    // Pending scoreboard: bits clear on the commit edge; a same-edge alloc re-sets them.
    always_comb begin
        alloc_hit_s = alloc_valid && (alloc_addr != REG_ZERO);
        set_vec_s   = alloc_hit_s ? reg_onehot(alloc_addr) : {NUM_REGS{1'b0}};
        clr_vec_s   = wr_en_q ? reg_onehot(wr_addr_q) : {NUM_REGS{1'b0}};
        alloc_err_d = alloc_err_q;
        if (flush) begin
            pending_d = set_vec_s;
        end else begin
            pending_d = (pending_q & ~clr_vec_s) | set_vec_s;
        end
        if (alloc_hit_s && !flush && pending_q[alloc_addr] && !clr_vec_s[alloc_addr]) begin
            alloc_err_d = 1'b1;
        end else begin
            alloc_err_d = alloc_err_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 32'd0;
            pending_q   <= {NUM_REGS{1'b0}};
            alloc_err_q <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pending_q   <= pending_d;
            alloc_err_q <= alloc_err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign pending   = pending_q;
    assign alloc_err = alloc_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; register-file writes are checked
// in order against a queue of expected {addr, data} pairs.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic        src0_valid, src0_ready;
    logic [4:0]  src0_addr;
    logic [31:0] src0_data;
    logic        src1_valid, src1_ready;
    logic [4:0]  src1_addr;
    logic [31:0] src1_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pending;
    logic        alloc_err;

    int checks = 0;
    int errors = 0;
    logic [36:0] sb_q[$];

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .src0_valid  (src0_valid),
        .src0_ready  (src0_ready),
        .src0_addr   (src0_addr),
        .src0_data   (src0_data),
        .src1_valid  (src1_valid),
        .src1_ready  (src1_ready),
        .src1_addr   (src1_addr),
        .src1_data   (src1_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pending     (pending),
        .alloc_err   (alloc_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        sb_q.push_back({a, d});
    endtask

    // Every register-file write must match the next expected write.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            logic [36:0] e;
            check("sb_expected_write", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_addr", 64'(wr_addr), 64'(e[36:32]));
                check("sb_data", 64'(wr_data), 64'(e[31:0]));
            end
        end
    end

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_addr = 5'd0; flush = 1'b0;
        src0_valid = 1'b0; src0_addr = 5'd0; src0_data = 32'd0;
        src1_valid = 1'b0; src1_addr = 5'd0; src1_data = 32'd0;
        tick(); tick();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_alloc_err", 64'(alloc_err), 64'd0);
        rst = 1'b0;

        // 1: single src0 write
        src0_valid = 1'b1; src0_addr = 5'd5; src0_data = 32'hDEAD_BEEF; #1;
        check("t1_ready0", 64'(src0_ready), 64'd1);
        check("t1_ready1", 64'(src1_ready), 64'd0);
        push(5'd5, 32'hDEAD_BEEF);
        tick(); src0_valid = 1'b0; #1;
        check("t1_wr_en", 64'(wr_en), 64'd1);
        check("t1_wr_addr", 64'(wr_addr), 64'd5);
        check("t1_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
        tick();
        check("t1_idle", 64'(wr_en), 64'd0);

        // 2: round-robin contention from a fresh reset
        rst = 1'b1; #1; rst = 1'b0;
        tick();
        src0_valid = 1'b1; src0_addr = 5'd3; src0_data = 32'h11;
        src1_valid = 1'b1; src1_addr = 5'd4; src1_data = 32'h22; #1;
        check("t2_first_ready0", 64'(src0_ready), 64'd1);
        check("t2_first_ready1", 64'(src1_ready), 64'd0);
        push(5'd3, 32'h11);
        tick(); src0_valid = 1'b0; #1;
        check("t2_second_ready1", 64'(src1_ready), 64'd1);
        check("t2_wr_r3", 64'(wr_addr), 64'd3);
        push(5'd4, 32'h22);
        tick();
        src0_valid = 1'b1; src0_addr = 5'd10; src0_data = 32'h33;
        src1_valid = 1'b1; src1_addr = 5'd11; src1_data = 32'h44; #1;
        check("t2_wr_en_b2b", 64'(wr_en), 64'd1);
        check("t2_wr_r4", 64'(wr_addr), 64'd4);
        check("t2_third_ready0", 64'(src0_ready), 64'd1);
        check("t2_third_ready1", 64'(src1_ready), 64'd0);
        push(5'd10, 32'h33);
        tick(); src0_valid = 1'b0; #1;
        check("t2_fourth_ready1", 64'(src1_ready), 64'd1);
        push(5'd11, 32'h44);
        tick(); src1_valid = 1'b0;
        tick();

        // 3: pending set by alloc, held through wr_en, cleared on commit
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        tick(); alloc_valid = 1'b0; #1;
        check("t3_pend_set", 64'(pending[7]), 64'd1);
        src1_valid = 1'b1; src1_addr = 5'd7; src1_data = 32'hA5; #1;
        check("t3_ready1", 64'(src1_ready), 64'd1);
        push(5'd7, 32'hA5);
        tick(); src1_valid = 1'b0; #1;
        check("t3_wr_en", 64'(wr_en), 64'd1);
        check("t3_pend_in_wr", 64'(pending[7]), 64'd1);
        tick();
        check("t3_pend_clr", 64'(pending[7]), 64'd0);

        // 4: alloc on the commit edge of the same register
        alloc_valid = 1'b1; alloc_addr = 5'd9;
        tick(); alloc_valid = 1'b0;
        src0_valid = 1'b1; src0_addr = 5'd9; src0_data = 32'h99; #1;
        push(5'd9, 32'h99);
        tick(); src0_valid = 1'b0; alloc_valid = 1'b1; alloc_addr = 5'd9; #1;
        check("t4_wr_r9", 64'(wr_addr), 64'd9);
        tick(); alloc_valid = 1'b0; #1;
        check("t4_pend_kept", 64'(pending[9]), 64'd1);
        check("t4_no_err", 64'(alloc_err), 64'd0);
        src0_valid = 1'b1; src0_data = 32'h9A; #1;
        push(5'd9, 32'h9A);
        tick(); src0_valid = 1'b0;
        tick();
        check("t4_pend_clr", 64'(pending[9]), 64'd0);

        // 5: double alloc error, then an r0 write
        alloc_valid = 1'b1; alloc_addr = 5'd2;
        tick();
        check("t5_err_first", 64'(alloc_err), 64'd0);
        tick(); alloc_valid = 1'b0; #1;
        check("t5_err_set", 64'(alloc_err), 64'd1);
        check("t5_pend_r2", 64'(pending[2]), 64'd1);
        tick(); tick();
        check("t5_err_sticky", 64'(alloc_err), 64'd1);
        src0_valid = 1'b1; src0_addr = 5'd0; src0_data = 32'h55; #1;
        check("t5_r0_ready", 64'(src0_ready), 64'd1);
        tick(); src0_valid = 1'b0; #1;
        check("t5_r0_no_wr", 64'(wr_en), 64'd0);
        check("t5_r0_pend", 64'(pending[0]), 64'd0);

        // 6: flush with alloc, then reset mid-grant
        flush = 1'b1;
        tick(); flush = 1'b0; #1;
        check("t6_flush_clr", 64'(pending), 64'd0);
        alloc_valid = 1'b1; alloc_addr = 5'd1;
        tick(); alloc_addr = 5'd6;
        tick(); alloc_valid = 1'b0; #1;
        check("t6_pend_r1_r6", 64'(pending), 64'h42);
        flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 5'd8;
        tick(); flush = 1'b0; alloc_valid = 1'b0; #1;
        check("t6_flush_alloc", 64'(pending), 64'h100);
        check("t6_err_still", 64'(alloc_err), 64'd1);
        src0_valid = 1'b1; src0_addr = 5'd12; src0_data = 32'h0C;
        tick(); src0_addr = 5'd13; src0_data = 32'h0D; #1;
        check("t6_pre_rst_wr", 64'(wr_en), 64'd1);
        rst = 1'b1; #1;
        check("t6_rst_wr_en", 64'(wr_en), 64'd0);
        check("t6_rst_pending", 64'(pending), 64'd0);
        check("t6_rst_err", 64'(alloc_err), 64'd0);
        check("t6_rst_wr_addr", 64'(wr_addr), 64'd0);
        tick(); rst = 1'b0; src0_valid = 1'b0;
        tick();
        check("t6_lost_grant", 64'(wr_en), 64'd0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: src0 (ALU) and src1 (load/store unit).
- Tracks per-register "write pending" state so the issue stage can detect read-after-write hazards.
- Sits between the execute/memory stages and the 32x32 register file. Drives the register file's write_enable, write_addr and write_data directly.
- Register 0 is hardwired zero: it is never written and never marked pending.

Parameters:
- NUM_REGS, 32, number of architectural registers (power of two).
- ADDR_W, 5, register address width (log2 NUM_REGS).
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alloc_valid  in  1  issue stage marks a destination register as pending
- alloc_addr  in  ADDR_W  destination register being allocated
- flush  in  1  pipeline flush; clears all pending bits
- src0_valid  in  1  ALU writeback request
- src0_ready  out  1  ALU request accepted this cycle
- src0_addr  in  ADDR_W  ALU destination register
- src0_data  in  DATA_W  ALU result
- src1_valid  in  1  LSU writeback request
- src1_ready  out  1  LSU request accepted this cycle
- src1_addr  in  ADDR_W  LSU destination register
- src1_data  in  DATA_W  load data
- wr_en  out  1  register-file write enable
- wr_addr  out  ADDR_W  register-file write address
- wr_data  out  DATA_W  register-file write data
- pending  out  NUM_REGS  bit r set = write to register r outstanding
- alloc_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, pending=0, alloc_err=0, last_grant=1 (src0 wins the first tie).
- Handshake:
  - A transfer occurs when srcN_valid && srcN_ready.
  - srcN_ready is combinational and equals grant N.
  - A source holds valid, addr and data stable until accepted.
  - The port never back-pressures when only one source is valid.
- Arbitration, round-robin:
  - One valid source: that source is granted.
  - Both valid: grant the source not recorded in last_grant.
  - last_grant updates on every grant.
  - Neither valid: no grant, last_grant unchanged.
- Output stage, registered, 1-cycle latency:
  - A grant in cycle N gives wr_en=1 with that addr/data in cycle N+1.
  - The register file commits on the edge ending cycle N+1.
- r0 requests:
  - Accepted normally (ready asserted, round-robin updated).
  - wr_en stays 0 for them; no effect on pending.
- Scoreboard:
  - alloc_valid with alloc_addr!=0 sets pending[alloc_addr] on the next edge.
  - pending[r] clears on the edge where wr_en=1 and wr_addr=r are sampled (the register-file commit edge). It is never cleared earlier, so a reader seeing pending=0 reads the committed value.
- Simultaneous events on the same edge, same register:
  - alloc and commit together: set wins (new producer).
  - flush clears all bits, then this cycle's alloc is applied, so an alloc in the flush cycle survives.
- Flush scope: flush does not cancel an in-flight wr_en or a pending grant. Writebacks of flushed instructions still reach the register file; the issue stage is responsible for squashing them upstream.
- alloc_err:
  - Set when alloc_valid targets a register whose pending bit is already set and that bit is not clearing on the same edge.
  - Sticky until rst.
  - The pending bit stays set in this case.
- Reset mid-operation: asynchronous rst immediately forces all outputs to their reset values. A request granted in the reset cycle is lost.
- No combinational path from src*_data to wr_data.

Decomposition:
- Shared package regfile_pkg holds:
  - constants NUM_REGS, ADDR_W, DATA_W, REG_ZERO=0;
  - typedef reg_addr_t;
  - typedef reg_data_t;
  - typedef wb_req_t, a struct {valid, addr, data}.
- One sub-module, rr_arbiter2: a 2-requester round-robin arbiter with a last_grant register.
- The scoreboard and output register live in the top module.

Test Plan:
1. Reset, then src0 alone writes r5=0xDEADBEEF in cycle 1 -> src0_ready=1 in cycle 1; wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in cycle 2; idle afterwards.
2. src0 (r3=0x11) and src1 (r4=0x22) both valid and held for 2 cycles -> src0 granted first, src1 second; consecutive wr_en cycles write r3 then r4; a third contention grants src0 again.
3. alloc r7, then src1 writes r7=0xA5 -> pending[7]=1 from the edge after alloc and stays set through the wr_en cycle; clears on the commit edge.
4. alloc r9 in the same cycle wr_en commits r9 -> pending[9] remains 1; alloc_err stays 0.
5. alloc r2 twice without an intervening write -> alloc_err=1 after the second alloc and stays 1; src0 request to r0 -> ready=1, wr_en stays 0, pending[0]=0.
6. pending={r1,r6}, then flush together with alloc r8 -> next edge pending has only bit 8 set; rst asserted mid-grant -> wr_en=0 and pending=0 immediately.
